pipe_adder: RTL and testbench

Parametrised, pipelined adder/subtractor for the ALU datapath. It splits a WIDTH-bit operation into STAGES equal segments and registers the carry between them, so the critical path is one segment wide. A valid/ready handshake lets it sit between the operand-fetch and writeback stages. It also produces the zero, sign and overflow condition flags that the branch unit consumes.

---
 rtl/pipe_adder.sv | 112 +++++++++++
 tb/tb_pipe_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES segments with a registered carry between them.
// Define PIPE_ADDER_FLAGS_EN to build the registered zf/sf/of flags; otherwise they are tied to 0.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  localparam int SEG = WIDTH / STAGES;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k sees only the operand bits not yet summed, and the sum bits already produced.
    localparam int UW = WIDTH - k * SEG;
    logic [UW-1:0]        xa, ya;
    logic                 ci, vin;
    logic [SEG:0]         seg;
    logic [(k+1)*SEG-1:0] s_d, s_q;
    logic                 vld_q, c_q;

    if (k == 0) begin : g_head
      assign xa  = x;
      assign ya  = sub ? ~y : y;
      assign ci  = sub;
      assign vin = in_valid;
      assign s_d = seg[SEG-1:0];
    end else begin : g_tail
      assign xa  = g_stage[k-1].g_fwd.xu_q;
      assign ya  = g_stage[k-1].g_fwd.yu_q;
      assign ci  = g_stage[k-1].c_q;
      assign vin = g_stage[k-1].vld_q;
      assign s_d = {seg[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg = {1'b0, xa[SEG-1:0]} + {1'b0, ya[SEG-1:0]} + {{SEG{1'b0}}, ci};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (en) begin
        vld_q <= vin;
        c_q   <= seg[SEG];
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [UW-SEG-1:0] xu_q, yu_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xu_q <= '0;
          yu_q <= '0;
        end else if (en) begin
          xu_q <= xa[UW-1:SEG];
          yu_q <= ya[UW-1:SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign f         = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;

`ifdef PIPE_ADDER_FLAGS_EN
  // Flags come from the last stage's combinational sum so they land in the same edge as f.
  logic zf_d, sf_d, of_d;
  logic zf_q, sf_q, of_q;
  assign zf_d = (g_stage[STAGES-1].s_d == '0);
  assign sf_d = g_stage[STAGES-1].s_d[WIDTH-1];
  assign of_d = (g_stage[STAGES-1].xa[SEG-1] == g_stage[STAGES-1].ya[SEG-1]) &&
                (sf_d != g_stage[STAGES-1].xa[SEG-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (en) begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed plan cases, backpressure, mid-flight reset, random stream, 8-bit 1-stage build.
module tb_pipe_adder;
  localparam int W = 32;
  localparam int S = 4;
`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk, rst;
  logic         in_valid, in_ready, sub, out_valid, out_ready, cout, zf, sf, of;
  logic [W-1:0] x, y, f;
  logic         in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, zf8, sf8, of8;
  logic [7:0]   x8, y8, f8;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .cout(cout), .zf(zf), .sf(sf), .of(of));

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .f(f8), .cout(cout8), .zf(zf8), .sf(sf8), .of(of8));

  typedef struct packed {
    logic [31:0] f;
    logic        cout, zf, sf, of;
  } res_t;

  res_t exp_q[$];
  res_t last;
  int   nchk = 0, nerr = 0, popped = 0;
  bit   last_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, signed range test for overflow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t        r;
    logic [32:0] t;
    longint      sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? sa - sb : sa + sb;
    t  = {1'b0, a} + {1'b0, b};
    r.f    = s ? a - b : a + b;
    r.cout = s ? (a >= b) : t[32];
    r.zf   = FLAGS && (r.f == 32'd0);
    r.sf   = FLAGS && r.f[31];
    r.of   = FLAGS && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
    return r;
  endfunction

  task automatic cycle();
    res_t e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      popped++;
      last = '{f: f, cout: cout, zf: zf, sf: sf, of: of};
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_f", 64'(f), 64'(e.f));
        check("sb_cout", 64'(cout), 64'(e.cout));
        check("sb_zf", 64'(zf), 64'(e.zf));
        check("sb_sf", 64'(sf), 64'(e.sf));
        check("sb_of", 64'(of), 64'(e.of));
      end
    end
    if (last_acc) exp_q.push_back(model(x, y, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    x = a; y = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    check({tag, "_acc"}, 64'(last_acc), 64'(1));
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      n++;
      cycle();
    end
    check({tag, "_latency"}, 64'(n), 64'(S));
  endtask

  initial begin
    int  i, guard;
    bit  stalled, gapchk;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; x8 = '0; y8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_f", 64'(f), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_flags", 64'({zf, sf, of}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    rst = 1'b0;

    directed("carry_prop", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("carry_prop_f", 64'(last.f), 64'h0);
    check("carry_prop_cout", 64'(last.cout), 64'(1));
    check("carry_prop_zf", 64'(last.zf), 64'(FLAGS));
    directed("borrow", 32'd5, 32'd7, 1'b1);
    check("borrow_f", 64'(last.f), 64'hFFFF_FFFE);
    check("borrow_cout", 64'(last.cout), 64'(0));
    check("borrow_sf", 64'(last.sf), 64'(FLAGS));
    directed("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0);
    check("ovf_add_f", 64'(last.f), 64'h8000_0000);
    check("ovf_add_of", 64'(last.of), 64'(FLAGS));
    check("ovf_add_cout", 64'(last.cout), 64'(0));
    directed("ovf_sub", 32'h8000_0000, 32'd1, 1'b1);
    check("ovf_sub_f", 64'(last.f), 64'h7FFF_FFFF);
    check("ovf_sub_of", 64'(last.of), 64'(FLAGS));
    check("ovf_sub_cout", 64'(last.cout), 64'(1));

    // Backpressure: stall while the second result (f=2) is presented.
    popped = 0; i = 0; stalled = 0; gapchk = 0; guard = 0; out_ready = 1'b1;
    while (popped < 8 && guard < 100) begin
      guard++;
      if (!stalled && popped == 1 && out_valid) begin
        stalled = 1; out_ready = 1'b0;
        in_valid = (i < 8); x = 32'(i); y = 32'(i); sub = 1'b0;
        for (int k = 0; k < 5; k++) begin
          cycle();
          if (last_acc) i++;
          check("bp_in_ready", 64'(in_ready), 64'(0));
          check("bp_hold_f", 64'(f), 64'(2));
          check("bp_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1; gapchk = 1;
      end
      in_valid = (i < 8); x = 32'(i); y = 32'(i); sub = 1'b0;
      if (gapchk) check("bp_no_gap", 64'(out_valid), 64'(1));
      cycle();
      if (last_acc) i++;
    end
    in_valid = 1'b0;
    check("bp_count", 64'(popped), 64'(8));
    check("bp_last_f", 64'(last.f), 64'(14));

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) begin
      x = 32'(100 + k); y = 32'd1; sub = 1'b0; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_f", 64'(f), 64'(0));
    check("mid_rst_cout", 64'(cout), 64'(0));
    check("mid_rst_flags", 64'({zf, sf, of}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("post_rst_stale", 64'(out_valid), 64'(0));
    end

    // Random stream with random backpressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      y   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sub = $urandom_range(0, 1) != 0;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      guard++;
      cycle();
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    // Single-stage 8-bit build.
    x8 = 8'h80; y8 = 8'h01; sub8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'(1));
    @(posedge clk);
    #1;
    x8 = 8'hFF; y8 = 8'h01; sub8 = 1'b0;
    @(negedge clk);
    check("w8_sub_valid", 64'(out_valid8), 64'(1));
    check("w8_sub_f", 64'(f8), 64'h7F);
    check("w8_sub_of", 64'(of8), 64'(FLAGS));
    check("w8_sub_cout", 64'(cout8), 64'(1));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_add_valid", 64'(out_valid8), 64'(1));
    check("w8_add_f", 64'(f8), 64'h00);
    check("w8_add_cout", 64'(cout8), 64'(1));
    check("w8_add_zf", 64'(zf8), 64'(FLAGS));
    @(posedge clk);
    #1;
    check("w8_idle_valid", 64'(out_valid8), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
